bcd_alu: RTL and testbench

//  Multi-cycle BCD arithmetic unit fed by the control FSM's execute strobe,

---
 rtl/bcd_alu.sv | 206 ++++++++++++++++++++
 tb/tb_bcd_alu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_alu.sv
// Multi-cycle BCD ALU: BCD->binary load, add/sub/mul/div, double-dabble back to BCD.
// Optional macro BCD_ALU_SATURATE_EN: overflow results read as all nines instead of zero.
//
// state | meaning
// IDLE  | waiting for execute, operands latched on the strobe
// LOAD  | operands converted to binary, digit check
// ARITH | add/sub one cycle, mul/div BIN_W cycles
// CONV  | BIN_W cycles of double-dabble
// DONE  | outputs updated, done pulse
module bcd_alu #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  execute,
    input  logic [1:0]            operator,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    output logic [4*DIGITS-1:0]   res_bcd,
    output logic                  neg,
    output logic                  ovf,
    output logic                  err,
    output logic                  busy,
    output logic                  done
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CW-1:0]      CNT_TOP = CW'(BIN_W - 1);
    localparam logic [2*BIN_W-1:0] MAX_MAG = (2*BIN_W)'(10**DIGITS - 1);

`ifdef BCD_ALU_SATURATE_EN
    localparam logic [BW-1:0] OVF_RES = {DIGITS{4'h9}};
`else
    localparam logic [BW-1:0] OVF_RES = '0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, ARITH, CONV, DONE} state_t;
    state_t state, state_nxt;

    logic [1:0]         op_q;
    logic [BW-1:0]      a_q, b_q;
    logic [BIN_W-1:0]   a_bin, b_bin;
    logic               inv_q;
    logic [2*BIN_W-1:0] mag, mcand;
    logic [BIN_W-1:0]   mplier, rem;
    logic               sign_q, ovf_q;
    logic [CW-1:0]      cnt;
    logic [BW-1:0]      bcd;
    logic [BIN_W-1:0]   bin_sh;

    logic               arith_last, conv_last, div_take, sign_nxt, err_nxt;
    logic [BIN_W:0]     rem_sh;
    logic [BIN_W-1:0]   rem_nxt, q_nxt;
    logic [2*BIN_W-1:0] mag_nxt;
    logic [BW-1:0]      bcd_shift;

    function automatic logic [BIN_W-1:0] to_bin(input logic [BW-1:0] v);
        logic [BIN_W-1:0] acc;
        acc = '0;
        for (int i = DIGITS - 1; i >= 0; i--)
            acc = acc * BIN_W'(10) + BIN_W'(v[4*i +: 4]);
        return acc;
    endfunction

    function automatic logic bad_digit(input logic [BW-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [BW-1:0] dd_adj(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        return r;
    endfunction

    assign arith_last = !op_q[1] || (cnt == '0);
    assign conv_last  = (cnt == '0);
    assign err_nxt    = inv_q || ((op_q == 2'b11) && (b_bin == '0));

    // One restoring-division step: mplier holds the dividend shifting into the quotient.
    always_comb begin
        rem_sh    = {rem, mplier[BIN_W-1]};
        div_take  = (rem_sh >= {1'b0, b_bin});
        rem_nxt   = div_take ? (rem_sh[BIN_W-1:0] - b_bin) : rem_sh[BIN_W-1:0];
        q_nxt     = {mplier[BIN_W-2:0], div_take};
        sign_nxt  = 1'b0;
        mag_nxt   = mag;
        case (op_q)
            2'b00: mag_nxt = (2*BIN_W)'(a_bin) + (2*BIN_W)'(b_bin);
            2'b01: begin
                if (a_bin >= b_bin) begin
                    mag_nxt = (2*BIN_W)'(a_bin - b_bin);
                end else begin
                    mag_nxt  = (2*BIN_W)'(b_bin - a_bin);
                    sign_nxt = 1'b1;
                end
            end
            2'b10:   mag_nxt = mplier[0] ? (mag + mcand) : mag;
            default: mag_nxt = (2*BIN_W)'(q_nxt);
        endcase
        bcd_shift = BW'({dd_adj(bcd), bin_sh[BIN_W-1]});
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (execute) state_nxt = LOAD;
            end
            LOAD:  state_nxt = ARITH;
            ARITH: if (arith_last) state_nxt = CONV;
            CONV:  if (conv_last) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_bin   <= '0;
            b_bin   <= '0;
            inv_q   <= 1'b0;
            mag     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt     <= '0;
            bcd     <= '0;
            bin_sh  <= '0;
            res_bcd <= '0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (execute) begin
                        op_q <= operator;
                        a_q  <= a_bcd;
                        b_q  <= b_bcd;
                    end
                end
                LOAD: begin
                    a_bin  <= to_bin(a_q);
                    b_bin  <= to_bin(b_q);
                    inv_q  <= bad_digit(a_q) || bad_digit(b_q);
                    mag    <= '0;
                    mcand  <= (2*BIN_W)'(to_bin(a_q));
                    mplier <= (op_q == 2'b10) ? to_bin(b_q) : to_bin(a_q);
                    rem    <= '0;
                    cnt    <= CNT_TOP;
                end
                ARITH: begin
                    mag    <= mag_nxt;
                    mcand  <= mcand << 1;
                    mplier <= (op_q == 2'b10) ? (mplier >> 1) : q_nxt;
                    rem    <= rem_nxt;
                    sign_q <= sign_nxt;
                    cnt    <= cnt - 1'b1;
                    if (arith_last) begin
                        cnt    <= CNT_TOP;
                        bin_sh <= mag_nxt[BIN_W-1:0];
                        bcd    <= '0;
                        ovf_q  <= !op_q[0] && (mag_nxt > MAX_MAG);
                    end
                end
                CONV: begin
                    bcd    <= bcd_shift;
                    bin_sh <= bin_sh << 1;
                    cnt    <= cnt - 1'b1;
                    if (conv_last) begin
                        res_bcd <= err_nxt ? '0 : (ovf_q ? OVF_RES : bcd_shift);
                        neg     <= sign_q && !err_nxt;
                        ovf     <= ovf_q;
                        err     <= err_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_alu.sv
// Scoreboard bench for bcd_alu: driver pushes model results, monitor pops on done.
module tb_bcd_alu;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          execute = 1'b0;
    logic [1:0]    operator = 2'b00;
    logic [BW-1:0] a_bcd = '0, b_bcd = '0;
    logic [BW-1:0] res_bcd;
    logic          neg, ovf, err, busy, done;

    bcd_alu #(.DIGITS(DIGITS), .BIN_W(10)) dut (
        .clock(clock), .reset_n(reset_n), .execute(execute), .operator(operator),
        .a_bcd(a_bcd), .b_bcd(b_bcd), .res_bcd(res_bcd), .neg(neg), .ovf(ovf),
        .err(err), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [BW-1:0] res;
        logic          neg;
        logic          ovf;
        logic          err;
        int            at;
    } exp_t;

    exp_t sb[$];
    int checks = 0, failures = 0;
    logic [BW-1:0] hold_res = '0;
    logic          hold_err = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                   input logic [1:0] op);
        exp_t e;
        int av, bv, r, d;
        bit inv;
        av = 0; bv = 0; r = 0; inv = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(a[4*i +: 4]); if (d > 9) inv = 1; av = av * 10 + d;
            d = int'(b[4*i +: 4]); if (d > 9) inv = 1; bv = bv * 10 + d;
        end
        e.err = inv || (op == 2'd3 && bv == 0);
        case (op)
            2'd0: r = av + bv;
            2'd1: r = (av >= bv) ? av - bv : bv - av;
            2'd2: r = av * bv;
            default: r = (bv == 0) ? 0 : av / bv;
        endcase
        e.ovf = (op == 2'd0 || op == 2'd2) && r > 999;
        e.neg = (op == 2'd1) && av < bv && !e.err;
        e.res = '0;
        if (!e.err && e.ovf) begin
`ifdef BCD_ALU_SATURATE_EN
            e.res = 12'h999;
`endif
        end else if (!e.err) begin
            for (int i = 0; i < DIGITS; i++) begin
                e.res[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
        end
        e.at = 0;
        return e;
    endfunction

    always @(negedge clock) begin
        if (reset_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_latency", cyc, e.at);
                    check("res_bcd", int'(res_bcd), int'(e.res));
                    check("neg", int'(neg), int'(e.neg));
                    check("err", int'(err), int'(e.err));
                    if (!e.err) check("ovf", int'(ovf), int'(e.ovf));
                    hold_res = e.res;
                    hold_err = e.err;
                end
            end else begin
                check("hold_res", int'(res_bcd), int'(hold_res));
                check("hold_err", int'(err), int'(hold_err));
            end
        end
    end

    task automatic issue(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [1:0] op);
        exp_t e;
        int n;
        n = 0;
        while (busy && n < 100) begin @(negedge clock); n++; end
        if (busy) check("idle_timeout", int'(busy), 0);
        @(negedge clock);
        a_bcd = a; b_bcd = b; operator = op; execute = 1'b1;
        @(negedge clock);
        execute = 1'b0;
        e = model(a, b, op);
        e.at = cyc + (op[1] ? 21 : 12);
        sb.push_back(e);
        check("busy_after_start", int'(busy), 1);
        a_bcd = BW'($urandom); b_bcd = BW'($urandom); operator = 2'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() > 0 || busy) && n < 200) begin @(negedge clock); n++; end
        if (sb.size() > 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    function automatic logic [BW-1:0] rand_bcd();
        logic [BW-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        repeat (2) @(negedge clock);
        check("rst_res", int'(res_bcd), 0);
        check("rst_flags", int'({neg, ovf, err}), 0);
        check("rst_busy_done", int'({busy, done}), 0);
        reset_n = 1'b1;

        issue(12'h123, 12'h456, 2'd0); drain();
        issue(12'h100, 12'h250, 2'd1); drain();
        issue(12'h250, 12'h250, 2'd1); drain();
        issue(12'h037, 12'h027, 2'd2); drain();
        issue(12'h500, 12'h500, 2'd0); drain();
        issue(12'h999, 12'h007, 2'd3); drain();
        issue(12'h999, 12'h000, 2'd3); drain();
        issue(12'h1A3, 12'h002, 2'd0); drain();
        issue(12'h999, 12'h999, 2'd2); drain();

        // Second execute lands on edge 5 of a mul and must be dropped.
        issue(12'h012, 12'h034, 2'd2);
        repeat (4) @(negedge clock);
        a_bcd = 12'h999; b_bcd = 12'h999; operator = 2'd0; execute = 1'b1;
        @(negedge clock);
        execute = 1'b0;
        drain();
        repeat (3) @(negedge clock);
        check("no_queued_op", int'(busy), 0);

        for (int k = 0; k < 40; k++) begin
            issue(rand_bcd(), rand_bcd(), 2'($urandom));
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        // Reset at edge 8 of a div after a nonzero result is showing.
        issue(12'h999, 12'h007, 2'd3); drain();
        issue(12'h999, 12'h007, 2'd3);
        repeat (7) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_res", int'(res_bcd), 0);
        check("abort_flags", int'({neg, ovf, err}), 0);
        check("abort_busy_done", int'({busy, done}), 0);
        sb.delete();
        hold_res = '0;
        hold_err = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        issue(12'h045, 12'h078, 2'd1); drain();
        issue(12'h064, 12'h008, 2'd3); drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
